// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the data-memory port arbiter: MemOp encodings,
// arbiter FSM states and requester port indices.
package rv32_mem_pkg;

    typedef enum logic [2:0] {
        MEMOP_LB  = 3'd0,
        MEMOP_LH  = 3'd1,
        MEMOP_LW  = 3'd2,
        MEMOP_LBU = 3'd3,
        MEMOP_LHU = 3'd4,
        MEMOP_SB  = 3'd5,
        MEMOP_SH  = 3'd6,
        MEMOP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// the port named by ptr.
module rr_arb2
    import rv32_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant_idx,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = ptr;
        if (req == 2'b01)
            grant_idx = PORT_C;
        else if (req == 2'b10)
            grant_idx = PORT_L;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data memory between the core (C) and the UART loader (L) through
// an IDLE/BUSY/RESP sequencer. Define DMEM_ARB_PERF_EN for perf counters.
module dmem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [2:0]        c_memop,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    output logic              cpu_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic [2:0]        l_memop,
    output logic              l_gnt,
    output logic              l_done,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_wr,
    output logic [2:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_stall
`endif
);

    arb_state_e        state, state_next;
    logic              owner, rr_ptr;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    mem_op_e           lat_memop;
    logic [1:0]        arb_req;
    logic              win_idx, win_valid, load_latch;

    // In RESP only the other port may chain; the owner is about to drop its request.
    always_comb begin
        arb_req = {l_req, c_req};
        if (state == ST_RESP)
            arb_req = (owner == PORT_C) ? {l_req, 1'b0} : {1'b0, c_req};
    end

    rr_arb2 u_rr_arb2 (
        .req         (arb_req),
        .ptr         (rr_ptr),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_latch = 1'b0;
        c_gnt      = 1'b0;
        l_gnt      = 1'b0;
        c_done     = 1'b0;
        l_done     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_op     = '0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_next = ST_BUSY;
                    load_latch = 1'b1;
                end
            end
            ST_BUSY: state_next = ST_RESP;
            ST_RESP: begin
                state_next = ST_IDLE;
                if (win_valid) begin
                    state_next = ST_BUSY;
                    load_latch = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (state == ST_BUSY || state == ST_RESP) begin
            c_gnt     = (owner == PORT_C);
            l_gnt     = (owner == PORT_L);
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_op    = lat_memop;
        end
        if (state == ST_RESP) begin
            c_done = (owner == PORT_C);
            l_done = (owner == PORT_L);
        end
        // Gating with rst aborts a store whose BUSY edge coincides with reset.
        mem_wr    = (state == ST_BUSY) && lat_we && !rst;
        c_rdata   = (c_done && !lat_we) ? mem_rdata : '0;
        l_rdata   = (l_done && !lat_we) ? mem_rdata : '0;
        cpu_stall = c_req && !c_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= PORT_C;
            rr_ptr    <= PORT_C;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_memop <= MEMOP_LB;
        end else begin
            if (state == ST_RESP)
                rr_ptr <= other_port(owner);
            if (load_latch) begin
                owner <= win_idx;
                if (win_idx == PORT_L) begin
                    lat_we    <= l_we;
                    lat_addr  <= l_addr;
                    lat_wdata <= l_wdata;
                    lat_memop <= mem_op_e'(l_memop);
                end else begin
                    lat_we    <= c_we;
                    lat_addr  <= c_addr;
                    lat_wdata <= c_wdata;
                    lat_memop <= mem_op_e'(c_memop);
                end
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict <= '0;
            perf_stall    <= '0;
        end else begin
            if (c_req && l_req && state != ST_BUSY && perf_conflict != 32'hFFFF_FFFF)
                perf_conflict <= perf_conflict + 32'd1;
            if (cpu_stall && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a word-addressed memory.
module tb_dmem_port_arbiter;
    import rv32_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic [2:0]  c_memop, l_memop;
    logic        c_gnt, c_done, cpu_stall, l_gnt, l_done;
    logic [31:0] c_rdata, l_rdata;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_conflict, perf_stall;
    logic [31:0] e_conf, e_stall;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] dmem    [512];
    logic [31:0] ref_mem [512];

    // reference model: one access in flight, aged 1 (address phase) or 2 (result phase)
    bit          m_active;
    int          m_age, m_own, m_ptr;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_memop;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_memop(c_memop),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata), .cpu_stall(cpu_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_memop(l_memop),
        .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
        .mem_wr(mem_wr), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_conflict(perf_conflict), .perf_stall(perf_stall)
`endif
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [5:0] ctrl();
        return {c_gnt, c_done, l_gnt, l_done, mem_wr, cpu_stall};
    endfunction

    // 2KB sync-write, 1-cycle-read memory seen by the DUT
    initial begin
        for (int i = 0; i < 512; i++) dmem[i] = init_word(i);
        forever begin
            @(posedge clk);
            mem_rdata <= dmem[mem_addr[10:2]];
            if (mem_wr) dmem[mem_addr[10:2]] = mem_wdata;
        end
    end

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_memop = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_memop = 0;
    endtask

    // Advance one clock and apply the arbitration rules to the reference model.
    task automatic step();
        logic s_rst, s_cr, s_lr;
        int   w;
        s_rst = rst; s_cr = c_req; s_lr = l_req;
`ifdef DMEM_ARB_PERF_EN
        if (s_rst) begin
            e_conf = 0; e_stall = 0;
        end else begin
            if (s_cr && s_lr && (!m_active || m_age == 2) && e_conf != 32'hFFFF_FFFF) e_conf++;
            if (s_cr && !(m_active && m_age == 2 && m_own == 0) && e_stall != 32'hFFFF_FFFF) e_stall++;
        end
`endif
        @(posedge clk);
        w = -1;
        if (s_rst) begin
            m_active = 0; m_own = 0; m_ptr = 0;
        end else if (m_active && m_age == 1) begin
            if (m_we) ref_mem[m_addr[10:2]] = m_wdata;
            m_age = 2;
        end else begin
            if (m_active) begin
                m_ptr = 1 - m_own;
                if ((m_own == 0) ? s_lr : s_cr) w = 1 - m_own;
            end else if (s_cr && s_lr) w = m_ptr;
            else if (s_cr) w = 0;
            else if (s_lr) w = 1;
            m_active = (w >= 0);
            m_age    = 1;
            if (w == 0) begin
                m_own = 0; m_we = c_we; m_addr = c_addr; m_wdata = c_wdata; m_memop = c_memop;
            end else if (w == 1) begin
                m_own = 1; m_we = l_we; m_addr = l_addr; m_wdata = l_wdata; m_memop = l_memop;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs(); rst = 1;
        step(); step();
        n_vec++;
        if (ctrl() !== 6'b0) begin
            n_miss++; $display("[TB] FAIL reset_ctrl: got %b want %b", ctrl(), 6'b0);
        end
        n_vec++;
        if ({mem_addr, mem_wdata, mem_op, c_rdata, l_rdata} !== '0) begin
            n_miss++; $display("[TB] FAIL reset_data: got addr %h wdata %h op %0d want all zero", mem_addr, mem_wdata, mem_op);
        end
        rst = 0;
    endtask

    task automatic test_l_store();
        idle_inputs();
        l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'h1234_5678; l_memop = MEMOP_SW;
        step();
        n_vec++;
        if (ctrl() !== 6'b001010) begin
            n_miss++; $display("[TB] FAIL lst_busy_ctrl: got %b want %b", ctrl(), 6'b001010);
        end
        n_vec++;
        if ({mem_addr, mem_wdata, mem_op} !== {32'h20, 32'h1234_5678, 3'(MEMOP_SW)}) begin
            n_miss++; $display("[TB] FAIL lst_busy_bus: got %h/%h/%0d want 20/12345678/%0d", mem_addr, mem_wdata, mem_op, MEMOP_SW);
        end
        l_wdata = 32'hFFFF_FFFF; l_addr = 32'h44;
        step();
        n_vec++;
        if (ctrl() !== 6'b001100) begin
            n_miss++; $display("[TB] FAIL lst_resp_ctrl: got %b want %b", ctrl(), 6'b001100);
        end
        n_vec++;
        if ({l_rdata, mem_addr, mem_wdata} !== {32'h0, 32'h20, 32'h1234_5678}) begin
            n_miss++; $display("[TB] FAIL lst_resp_data: got rdata %h addr %h wdata %h want 0/20/12345678", l_rdata, mem_addr, mem_wdata);
        end
        l_req = 0;
        step();
        n_vec++;
        if ({ctrl(), mem_addr} !== {6'b0, 32'h0}) begin
            n_miss++; $display("[TB] FAIL lst_idle: got %b addr %h want 000000 addr 0", ctrl(), mem_addr);
        end
    endtask

    task automatic test_c_load();
        idle_inputs();
        l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF; l_memop = MEMOP_SW;
        step(); step(); l_req = 0; step();
        c_req = 1; c_we = 0; c_addr = 32'h10; c_memop = MEMOP_LW;
        #1;
        n_vec++;
        if (ctrl() !== 6'b000001) begin
            n_miss++; $display("[TB] FAIL cld_req_ctrl: got %b want %b", ctrl(), 6'b000001);
        end
        step();
        n_vec++;
        if ({ctrl(), mem_addr} !== {6'b100001, 32'h10}) begin
            n_miss++; $display("[TB] FAIL cld_busy: got %b addr %h want 100001 addr 10", ctrl(), mem_addr);
        end
        step();
        n_vec++;
        if ({ctrl(), c_rdata} !== {6'b110000, 32'hDEAD_BEEF}) begin
            n_miss++; $display("[TB] FAIL cld_resp: got %b rdata %h want 110000 rdata deadbeef", ctrl(), c_rdata);
        end
        c_req = 0;
        step();
    endtask

    task automatic test_conflict();
        idle_inputs(); rst = 1; step(); rst = 0;
        c_req = 1; c_addr = 32'h20; c_memop = MEMOP_LW;
        l_req = 1; l_addr = 32'h10; l_memop = MEMOP_LW;
        step();
        n_vec++;
        if (ctrl() !== 6'b100001) begin
            n_miss++; $display("[TB] FAIL cfl1_busy: got %b want %b", ctrl(), 6'b100001);
        end
        step();
        n_vec++;
        if ({ctrl(), c_rdata} !== {6'b110000, 32'h1234_5678}) begin
            n_miss++; $display("[TB] FAIL cfl1_cdone: got %b rdata %h want 110000 rdata 12345678", ctrl(), c_rdata);
        end
        c_req = 0;
        step();
        n_vec++;
        if ({ctrl(), mem_addr} !== {6'b001000, 32'h10}) begin
            n_miss++; $display("[TB] FAIL cfl1_chain: got %b addr %h want 001000 addr 10", ctrl(), mem_addr);
        end
        step();
        n_vec++;
        if ({ctrl(), l_rdata} !== {6'b001100, 32'hDEAD_BEEF}) begin
            n_miss++; $display("[TB] FAIL cfl1_ldone: got %b rdata %h want 001100 rdata deadbeef", ctrl(), l_rdata);
        end
        l_req = 0;
        step();
        c_req = 1; step(); step(); c_req = 0; step();
        c_req = 1; l_req = 1;
        step();
        n_vec++;
        if (ctrl() !== 6'b001001) begin
            n_miss++; $display("[TB] FAIL cfl2_lfirst: got %b want %b", ctrl(), 6'b001001);
        end
        step();
        n_vec++;
        if (ctrl() !== 6'b001101) begin
            n_miss++; $display("[TB] FAIL cfl2_ldone: got %b want %b", ctrl(), 6'b001101);
        end
        l_req = 0;
        step(); step();
        n_vec++;
        if ({ctrl(), c_rdata} !== {6'b110000, 32'h1234_5678}) begin
            n_miss++; $display("[TB] FAIL cfl2_cdone: got %b rdata %h want 110000 rdata 12345678", ctrl(), c_rdata);
        end
        c_req = 0;
        step();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'hCAFE_F00D; l_memop = MEMOP_SW;
        step();
        n_vec++;
        if (ctrl() !== 6'b001010) begin
            n_miss++; $display("[TB] FAIL rmid_busy: got %b want %b", ctrl(), 6'b001010);
        end
        rst = 1;
        #1;
        n_vec++;
        if (mem_wr !== 1'b0) begin
            n_miss++; $display("[TB] FAIL rmid_wr_gate: got %b want 0", mem_wr);
        end
        step();
        n_vec++;
        if ({ctrl(), mem_addr, mem_wdata, l_rdata} !== {6'b0, 96'h0}) begin
            n_miss++; $display("[TB] FAIL rmid_idle: got %b addr %h wdata %h want all zero", ctrl(), mem_addr, mem_wdata);
        end
        rst = 0; l_req = 0;
        step();
    endtask

    task automatic test_drop_in_busy();
        idle_inputs();
        c_req = 1; c_addr = 32'h40; c_memop = MEMOP_LW;
        step();
        c_req = 0;
        step();
        n_vec++;
        if ({ctrl(), c_rdata} !== {6'b110000, init_word(16)}) begin
            n_miss++; $display("[TB] FAIL drop_done: got %b rdata %h want 110000 rdata %h", ctrl(), c_rdata, init_word(16));
        end
        step();
        n_vec++;
        if ({ctrl(), mem_addr} !== {6'b0, 32'h0}) begin
            n_miss++; $display("[TB] FAIL drop_idle: got %b addr %h want 000000 addr 0", ctrl(), mem_addr);
        end
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        idle_inputs(); rst = 1; step(); rst = 0;
        n_vec++;
        if ({perf_conflict, perf_stall} !== 64'h0) begin
            n_miss++; $display("[TB] FAIL perf_reset: got %0d/%0d want 0/0", perf_conflict, perf_stall);
        end
        c_req = 1; l_req = 1;
        for (int i = 0; i < 5; i++) step();
        n_vec++;
        if ({perf_conflict, perf_stall} !== {32'd3, 32'd4}) begin
            n_miss++; $display("[TB] FAIL perf_count: got %0d/%0d want 3/4", perf_conflict, perf_stall);
        end
        idle_inputs();
        step(); step(); step();
    endtask
`endif

    task automatic test_random(int cycles);
        logic [5:0]  e_ctrl;
        logic [31:0] e_crd, e_lrd;
        bit          e_cd, e_ld;
        for (int k = 0; k < cycles; k++) begin
            e_cd = m_active && m_age == 2 && m_own == 0;
            e_ld = m_active && m_age == 2 && m_own == 1;
            rst = ($urandom_range(0, 99) == 0);
            if (e_cd) c_req = 0;
            else if (!c_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    c_req = 1; c_we = 1'($urandom_range(0, 1)); c_addr = $urandom(); c_wdata = $urandom(); c_memop = 3'($urandom_range(0, 7));
                end
            end else if ($urandom_range(0, 15) == 0) c_req = 0;
            else if ($urandom_range(0, 3) == 0) begin
                c_we = 1'($urandom_range(0, 1)); c_addr = $urandom(); c_wdata = $urandom(); c_memop = 3'($urandom_range(0, 7));
            end
            if (e_ld) l_req = 0;
            else if (!l_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    l_req = 1; l_we = 1'($urandom_range(0, 1)); l_addr = $urandom(); l_wdata = $urandom(); l_memop = 3'($urandom_range(0, 7));
                end
            end else if ($urandom_range(0, 15) == 0) l_req = 0;
            else if ($urandom_range(0, 3) == 0) begin
                l_we = 1'($urandom_range(0, 1)); l_addr = $urandom(); l_wdata = $urandom(); l_memop = 3'($urandom_range(0, 7));
            end
            step();
            e_cd   = m_active && m_age == 2 && m_own == 0;
            e_ld   = m_active && m_age == 2 && m_own == 1;
            e_ctrl = {m_active && m_own == 0, e_cd, m_active && m_own == 1, e_ld,
                      m_active && m_age == 1 && m_we && !rst, c_req && !e_cd};
            e_crd  = (e_cd && !m_we) ? ref_mem[m_addr[10:2]] : 32'h0;
            e_lrd  = (e_ld && !m_we) ? ref_mem[m_addr[10:2]] : 32'h0;
            n_vec++;
            if (ctrl() !== e_ctrl) begin
                n_miss++; $display("[TB] FAIL rnd_ctrl cyc %0d: got %b want %b", k, ctrl(), e_ctrl);
            end
            n_vec++;
            if (c_rdata !== e_crd) begin
                n_miss++; $display("[TB] FAIL rnd_c_rdata cyc %0d: got %h want %h", k, c_rdata, e_crd);
            end
            n_vec++;
            if (l_rdata !== e_lrd) begin
                n_miss++; $display("[TB] FAIL rnd_l_rdata cyc %0d: got %h want %h", k, l_rdata, e_lrd);
            end
            n_vec++;
            if (mem_addr !== (m_active ? m_addr : 32'h0)) begin
                n_miss++; $display("[TB] FAIL rnd_mem_addr cyc %0d: got %h want %h", k, mem_addr, m_active ? m_addr : 32'h0);
            end
            n_vec++;
            if (mem_wdata !== (m_active ? m_wdata : 32'h0)) begin
                n_miss++; $display("[TB] FAIL rnd_mem_wdata cyc %0d: got %h want %h", k, mem_wdata, m_active ? m_wdata : 32'h0);
            end
            n_vec++;
            if (mem_op !== (m_active ? m_memop : 3'h0)) begin
                n_miss++; $display("[TB] FAIL rnd_mem_op cyc %0d: got %0d want %0d", k, mem_op, m_active ? m_memop : 3'h0);
            end
        end
`ifdef DMEM_ARB_PERF_EN
        n_vec++;
        if ({perf_conflict, perf_stall} !== {e_conf, e_stall}) begin
            n_miss++; $display("[TB] FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_conflict, perf_stall, e_conf, e_stall);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
        m_active = 0; m_age = 0; m_own = 0; m_ptr = 0;
        m_we = 0; m_addr = 0; m_wdata = 0; m_memop = 0;
        idle_inputs();
        rst = 1;
        test_reset();
        test_l_store();
        test_c_load();
        test_conflict();
        test_reset_mid();
        test_drop_in_busy();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
